// File: rtl/seaccow_pkt_fifo.sv
// seaccow_pkt_fifo: FWFT Avalon-ST packet FIFO; define SEACCOW_FIFO_STORE_FWD_EN to hold packets until complete
module seaccow_pkt_fifo #(
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = $clog2(DATA_W/8),
  parameter int ADDR_W    = 8,
  parameter int AFULL_LVL = 2**ADDR_W - 4
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W:0]    level,
  output logic               almost_full
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int BW = DATA_W + EMPTY_W + 2;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] AFULL = (ADDR_W+1)'(AFULL_LVL);
  logic [BW-1:0] mem [DEPTH];
  logic [BW-1:0] in_beat, head;
  logic [ADDR_W-1:0] wp, rp, rp_nxt;
  logic [ADDR_W:0] count;
  logic wr, rd;
  assign in_beat = {in_data, in_sop, in_eop, in_eop ? in_empty : '0};
  assign rp_nxt = rp + 1'b1;
  assign in_ready = count < FULL;
  assign wr = in_valid && in_ready;
  assign rd = out_valid && out_ready;
  assign {out_data, out_sop, out_eop, out_empty} = head;
  assign level = count;
  assign almost_full = count >= AFULL;
`ifdef SEACCOW_FIFO_STORE_FWD_EN
  logic [ADDR_W:0] pkts;
  assign out_valid = count != '0 && (pkts != '0 || count == FULL);
  // complete packets held: one per stored eop beat
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) pkts <= '0;
    else if ((wr && in_eop) != (rd && out_eop)) pkts <= (wr && in_eop) ? pkts + 1'b1 : pkts - 1'b1;
`else
  assign out_valid = count != '0;
`endif
  // beat storage; contents survive reset but become unreachable
  always_ff @(posedge sys_clk)
    if (wr) mem[wp] <= in_beat;
  // pointers, occupancy and the head register; the head bypasses RAM when the FIFO is (about to go) empty
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      head <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp_nxt;
      if (wr != rd) count <= wr ? count + 1'b1 : count - 1'b1;
      if (wr && (count == '0 || (rd && count == ONE))) head <= in_beat;
      else if (rd) head <= mem[rp_nxt];
    end
endmodule
